// File: rtl/game_pkg.sv
// Shared framing definitions for the game status line: ASCII constants,
// line length, top-FSM encoding and the character selector.
package game_pkg;

    localparam int STATUS_LEN = 11;

    localparam logic [7:0] ASCII_T  = 8'h54;
    localparam logic [7:0] ASCII_X  = 8'h58;
    localparam logic [7:0] ASCII_S  = 8'h53;
    localparam logic [7:0] ASCII_EQ = 8'h3D;
    localparam logic [7:0] ASCII_SP = 8'h20;
    localparam logic [7:0] ASCII_CR = 8'h0D;
    localparam logic [7:0] ASCII_LF = 8'h0A;

    // The load step is folded into the cycle that hands a byte to the engine,
    // so only IDLE and WAIT ever sit in the state register.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd2
    } top_state_e;

    typedef struct packed {
        logic       done;
        logic [6:0] time_msb;
        logic [6:0] time_lsb;
        logic [6:0] score_msb;
        logic [6:0] score_lsb;
    } snap_t;

    function automatic logic [7:0] status_char(input logic [3:0] i, input snap_t s);
        case (i)
            4'd0:    return s.done ? ASCII_X : ASCII_T;
            4'd1:    return ASCII_EQ;
            4'd2:    return {1'b0, s.time_msb};
            4'd3:    return {1'b0, s.time_lsb};
            4'd4:    return ASCII_SP;
            4'd5:    return ASCII_S;
            4'd6:    return ASCII_EQ;
            4'd7:    return {1'b0, s.score_msb};
            4'd8:    return {1'b0, s.score_lsb};
            4'd9:    return ASCII_CR;
            default: return ASCII_LF;
        endcase
    endfunction

endpackage

// File: rtl/uart_tx_byte.sv
// 8N1 byte transmitter. A start request during the last stop-bit cycle is
// accepted immediately so consecutive bytes run with no idle gap.
module uart_tx_byte #(
    parameter int CLKS_PER_BIT = 868
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [7:0] data,
    output logic       tx,
    output logic       busy,
    output logic       done
);

    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);

    typedef enum logic [1:0] {
        B_IDLE,
        B_START,
        B_DATA,
        B_STOP
    } byte_state_e;

    byte_state_e     state, state_n;
    logic [CW-1:0]   cnt;
    logic [2:0]      bit_idx;
    logic [7:0]      shreg;
    logic            bit_end;
    logic            accept;

    assign bit_end = (cnt == CNT_LAST);
    assign done    = (state == B_STOP) && bit_end;
    assign busy    = (state != B_IDLE);
    assign accept  = start && ((state == B_IDLE) || done);

    always_ff @(posedge clk) begin
        if (rst) state <= B_IDLE;
        else     state <= state_n;
    end

    always_comb begin
        state_n = state;
        case (state)
            B_IDLE:  if (start) state_n = B_START;
            B_START: if (bit_end) state_n = B_DATA;
            B_DATA:  if (bit_end && bit_idx == 3'd7) state_n = B_STOP;
            B_STOP:  if (bit_end) state_n = start ? B_START : B_IDLE;
            default: state_n = B_IDLE;
        endcase
    end

    // Line driver and shifter: tx is registered so it changes on the bit edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt     <= '0;
            bit_idx <= '0;
            shreg   <= '0;
            tx      <= 1'b1;
        end else if (accept) begin
            cnt     <= '0;
            bit_idx <= '0;
            shreg   <= data;
            tx      <= 1'b0;
        end else if (state != B_IDLE) begin
            cnt <= bit_end ? '0 : cnt + 1'b1;
            if (bit_end) begin
                case (state)
                    B_START: begin
                        tx    <= shreg[0];
                        shreg <= shreg >> 1;
                    end
                    B_DATA: begin
                        if (bit_idx == 3'd7) begin
                            tx <= 1'b1;
                        end else begin
                            tx      <= shreg[0];
                            shreg   <= shreg >> 1;
                            bit_idx <= bit_idx + 3'd1;
                        end
                    end
                    default: tx <= 1'b1;
                endcase
            end
        end
    end

endmodule

// File: rtl/status_uart_tx.sv
// Snapshots the timer/score digits and streams the 11-character status line
// through the byte engine, back to back.
module status_uart_tx
    import game_pkg::*;
#(
    parameter int CLKS_PER_BIT = 868
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       send,
    input  logic [6:0] time_MSB_ascii,
    input  logic [6:0] time_LSB_ascii,
    input  logic [6:0] score_MSB_ascii,
    input  logic [6:0] score_LSB_ascii,
    input  logic       timer_done,
    output logic       tx,
    output logic       busy,
    output logic       frame_done
);

    top_state_e state, state_n;
    logic [3:0] idx;
    snap_t      snap, live;
    logic       accept, last_char, byte_done, eng_busy, start;
    logic [7:0] data;

    assign live = '{done: timer_done, time_msb: time_MSB_ascii, time_lsb: time_LSB_ascii,
                    score_msb: score_MSB_ascii, score_lsb: score_LSB_ascii};

    assign accept    = (state == ST_IDLE) && send;
    assign last_char = (idx == 4'(STATUS_LEN - 1));

    always_ff @(posedge clk) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_n;
    end

    always_comb begin
        state_n = state;
        case (state)
            ST_IDLE: if (send) state_n = ST_WAIT;
            ST_WAIT: if (byte_done && last_char) state_n = ST_IDLE;
            default: state_n = ST_IDLE;
        endcase
    end

    // char0 comes from the live inputs so its start bit can begin on the
    // accepting edge; every later char comes from the snapshot.
    always_comb begin
        start = accept || ((state == ST_WAIT) && byte_done && !last_char);
        data  = accept ? status_char(4'd0, live) : status_char(idx + 4'd1, snap);
        busy  = (state != ST_IDLE) || eng_busy;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            idx        <= '0;
            snap       <= '0;
            frame_done <= 1'b0;
        end else begin
            frame_done <= (state == ST_WAIT) && byte_done && last_char;
            if (accept) begin
                snap <= live;
                idx  <= '0;
            end else if ((state == ST_WAIT) && byte_done && !last_char) begin
                idx <= idx + 4'd1;
            end
        end
    end

    uart_tx_byte #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_byte (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .data  (data),
        .tx    (tx),
        .busy  (eng_busy),
        .done  (byte_done)
    );

endmodule

// File: tb/tb_status_uart_tx.sv
// Directed + randomized bench: each line is predicted as a string, expanded
// to an 8N1 bit stream, and compared cycle by cycle and byte by byte.
module tb_status_uart_tx;

    localparam int CPB   = 4;
    localparam int BYTEC = 10 * CPB;
    localparam int FRAME = 11 * BYTEC;

    localparam int M_NORMAL = 0;
    localparam int M_CHANGE = 1;
    localparam int M_GLITCH = 2;
    localparam int M_RESET  = 3;
    localparam int M_HOLD   = 4;

    logic       clk = 1'b0;
    logic       rst, send, td;
    logic [6:0] tm, tl, sm, sl;
    logic       tx, busy, frame_done;

    int n_chk  = 0;
    int n_fail = 0;

    logic [7:0] exp_line [11];

    always #5 clk = ~clk;

    status_uart_tx #(.CLKS_PER_BIT(CPB)) dut (
        .clk             (clk),
        .rst             (rst),
        .send            (send),
        .time_MSB_ascii  (tm),
        .time_LSB_ascii  (tl),
        .score_MSB_ascii (sm),
        .score_LSB_ascii (sl),
        .timer_done      (td),
        .tx              (tx),
        .busy            (busy),
        .frame_done      (frame_done)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Line bit t: each char is 10 bits (start, 8 data LSB first, stop) of CPB cycles.
    function automatic logic exp_tx(input int t);
        int p, b;
        p = t / BYTEC;
        b = (t % BYTEC) / CPB;
        if (b == 0) return 1'b0;
        if (b == 9) return 1'b1;
        return exp_line[p][b-1];
    endfunction

    task automatic check_idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            chk("idle_tx", tx, 1);
            chk("idle_busy", busy, 0);
            chk("idle_frame_done", frame_done, 0);
        end
    endtask

    task automatic run_frame(input logic [6:0] a, input logic [6:0] b, input logic [6:0] c,
                             input logic [6:0] d, input logic done_in, input int mode);
        logic [7:0] rx;
        bit aborted;
        rx = '0;
        aborted = 0;
        @(negedge clk);
        tm = a; tl = b; sm = c; sl = d; td = done_in; send = 1'b1;
        exp_line = '{done_in ? 8'h58 : 8'h54, 8'h3D, {1'b0, a}, {1'b0, b}, 8'h20, 8'h53,
                     8'h3D, {1'b0, c}, {1'b0, d}, 8'h0D, 8'h0A};
        for (int t = 0; t < FRAME; t++) begin
            @(negedge clk);
            if (mode == M_RESET && t == 200) begin
                chk("reset_tx", tx, 1);
                chk("reset_busy", busy, 0);
                chk("reset_frame_done", frame_done, 0);
                rst = 1'b0;
                aborted = 1;
                break;
            end
            chk("line_tx", tx, exp_tx(t));
            chk("line_busy", busy, 1);
            chk("line_frame_done", frame_done, 0);
            if (t % CPB == CPB / 2) begin
                int bi;
                bi = (t % BYTEC) / CPB;
                if (bi >= 1 && bi <= 8) rx[bi-1] = tx;
                if (bi == 9) chk("decoded_byte", rx, exp_line[t / BYTEC]);
            end
            if (t == 0 && mode != M_HOLD) send = 1'b0;
            if (mode == M_CHANGE && t == 50) begin
                tm = 7'h30; tl = 7'h30; sm = 7'h31; sl = 7'h32; td = ~done_in;
            end
            if (mode == M_GLITCH && t == 99)  send = 1'b1;
            if (mode == M_GLITCH && t == 100) send = 1'b0;
            if (mode == M_RESET && t == 199)  rst = 1'b1;
        end
        if (aborted) begin
            check_idle(FRAME + 20);
        end else begin
            @(negedge clk);
            chk("end_tx", tx, 1);
            chk("end_busy", busy, 0);
            chk("end_frame_done", frame_done, 1);
            if (mode == M_HOLD) begin
                @(negedge clk);
                chk("hold_restart_busy", busy, 1);
                chk("hold_restart_tx", tx, 0);
                chk("hold_frame_done", frame_done, 0);
                send = 1'b0;
                rst  = 1'b1;
                @(negedge clk);
                rst = 1'b0;
                chk("hold_reset_busy", busy, 0);
                check_idle(5);
            end else begin
                check_idle(mode == M_GLITCH ? FRAME + 60 : 20);
            end
        end
    endtask

    initial begin
        rst = 1'b1; send = 1'b0; td = 1'b0;
        tm = 7'h30; tl = 7'h30; sm = 7'h30; sl = 7'h30;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        check_idle(50);

        run_frame(7'h33, 7'h31, 7'h30, 7'h35, 1'b0, M_CHANGE);
        run_frame(7'h30, 7'h30, 7'h31, 7'h35, 1'b1, M_NORMAL);
        run_frame(7'h31, 7'h32, 7'h33, 7'h34, 1'b0, M_GLITCH);
        run_frame(7'h32, 7'h32, 7'h37, 7'h37, 1'b0, M_RESET);
        run_frame(7'h33, 7'h31, 7'h30, 7'h35, 1'b0, M_NORMAL);

        for (int r = 0; r < 4; r++) begin
            logic [6:0] ra, rb, rc, rd;
            logic       rdn;
            ra  = 7'(8'h30 + $urandom_range(0, 3));
            rb  = 7'(8'h30 + $urandom_range(0, 9));
            rc  = 7'(8'h30 + $urandom_range(0, 9));
            rd  = 7'(8'h30 + $urandom_range(0, 9));
            rdn = 1'($urandom_range(0, 1));
            run_frame(ra, rb, rc, rd, rdn, (r == 3) ? M_HOLD : M_NORMAL);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
